// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control and pattern bus between the stimulus controller and the LFSR generator
interface lfsr_gen_if #(
  parameter int WIDTH = 26,
  parameter int STEPS = 1
);
  logic             en;
  logic             load;
  logic [1:WIDTH]   din;
  logic [1:WIDTH]   q;
  logic [1:STEPS]   out_bits;
  logic             wrap;
  logic [WIDTH-1:0] period;
  modport master (output en, load, din, input q, out_bits, wrap, period);
  modport slave  (input en, load, din, output q, out_bits, wrap, period);
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Galois LFSR with enable, multi-step advance and zero-state recovery.
// Define LFSR_GEN_WRAP_EN to add period-wrap detection (wrap/period outputs).
module lfsr_gen #(
  parameter int             WIDTH = 26,
  parameter logic [1:WIDTH] TAPS  = 26'b01000011000000000000000000,
  parameter logic [1:WIDTH] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int             STEPS = 1
) (
  input logic        clk,
  input logic        rst_n,
  lfsr_gen_if.slave  b
);
  localparam logic [1:WIDTH] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  logic [1:WIDTH] q, adv, ld;
  logic [1:STEPS] out_bits, ob;
  logic           zero;
  function automatic logic [1:WIDTH] shift1(input logic [1:WIDTH] s);
    shift1 = {s[WIDTH], s[1:WIDTH-1] ^ (TAPS[2:WIDTH] & {(WIDTH-1){s[WIDTH]}})};
  endfunction
  // STEPS single shifts unrolled; each step records the bit leaving stage WIDTH
  always_comb begin
    adv = q;
    ob  = '0;
    for (int k = 1; k <= STEPS; k++) begin
      ob[k] = adv[WIDTH];
      adv   = shift1(adv);
    end
  end
  assign zero = q == '0;
  assign ld   = |b.din ? b.din : ONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= SEED;
      out_bits <= '0;
    end else if (b.load) begin
      q        <= ld;
      out_bits <= '0;
    end else if (b.en) begin
      q        <= zero ? ONE : adv;
      out_bits <= zero ? '0 : ob;
    end
  end
  assign b.q        = q;
  assign b.out_bits = out_bits;
`ifdef LFSR_GEN_WRAP_EN
  logic [1:WIDTH]   start;
  logic [WIDTH-1:0] cnt, period;
  logic             wrap;
  // start tracks the state a period is measured from: seed, loaded value or recovered 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start  <= SEED;
      cnt    <= '0;
      period <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (b.load) begin
        start <= ld;
        cnt   <= '0;
      end else if (b.en && zero) begin
        start <= ONE;
        cnt   <= '0;
      end else if (b.en) begin
        if (adv == start) begin
          wrap   <= 1'b1;
          period <= cnt + 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
  assign b.wrap   = wrap;
  assign b.period = period;
`else
  assign b.wrap   = 1'b0;
  assign b.period = '0;
`endif
endmodule
